// File: rtl/wav_dfi_lp_pkg.sv
// Shared types and helpers for the DFI low-power responder.
// Optional stats counters are enabled with WAV_DFI_LP_RESP_STATS_EN.
package wav_dfi_lp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, EXIT} lp_state_e;

  localparam int unsigned LP_WAKEUP_W = 6;

  function automatic logic [LP_WAKEUP_W-1:0] sat_exit(
    input logic [LP_WAKEUP_W-1:0] wakeup,
    input int unsigned            max
  );
    if (32'(wakeup) > max) sat_exit = LP_WAKEUP_W'(max);
    else                   sat_exit = wakeup;
  endfunction

endpackage

// File: rtl/wav_dfi_lp_chan.sv
// One DFI low-power handshake channel: IDLE/WAIT/ACK/EXIT FSM with delay counters.
// Entry/abort counters are present only with WAV_DFI_LP_RESP_STATS_EN.
module wav_dfi_lp_chan
  import wav_dfi_lp_pkg::*;
#(
  parameter int unsigned TLP_RESP = 8,
  parameter int unsigned MAX_EXIT = 63,
  parameter int unsigned DLY_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic [LP_WAKEUP_W-1:0] wakeup,
  input  logic [DLY_W-1:0]       cfg_resp_dly,
  input  logic                   cfg_allow,
  output logic                   ack,
  output logic                   active
`ifdef WAV_DFI_LP_RESP_STATS_EN
  ,
  output logic [15:0]            entries,
  output logic [15:0]            aborts
`endif
);

  localparam int unsigned CNT_W = (DLY_W > LP_WAKEUP_W) ? DLY_W : LP_WAKEUP_W;

  lp_state_e              state;
  logic [CNT_W-1:0]       cnt;
  logic [LP_WAKEUP_W-1:0] wk_q;
  logic                   resp_ok;

  // A delay whose ack would land after the MC's tlp_resp window is never acknowledged.
  assign resp_ok = (32'(cfg_resp_dly) + 32'd1) <= TLP_RESP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wk_q    <= '0;
      ack     <= 1'b0;
      active  <= 1'b0;
`ifdef WAV_DFI_LP_RESP_STATS_EN
      entries <= '0;
      aborts  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            cnt   <= CNT_W'(cfg_resp_dly);
            wk_q  <= wakeup;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
`ifdef WAV_DFI_LP_RESP_STATS_EN
            if (aborts != '1) aborts <= aborts + 16'd1;
`endif
          end else begin
            wk_q <= wakeup;
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (cfg_allow && resp_ok) begin
              state  <= ACK;
              ack    <= 1'b1;
              active <= 1'b1;
`ifdef WAV_DFI_LP_RESP_STATS_EN
              if (entries != '1) entries <= entries + 16'd1;
`endif
            end
          end
        end
        ACK: begin
          // wk_q holds the code from the last cycle req was sampled high.
          if (req) begin
            wk_q <= wakeup;
          end else begin
            state  <= EXIT;
            cnt    <= CNT_W'(sat_exit(wk_q, MAX_EXIT));
            active <= 1'b0;
          end
        end
        EXIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wav_dfi_lp_responder.sv
// PHY-side DFI low-power responder: independent control and data channels.
// Define WAV_DFI_LP_RESP_STATS_EN to add per-channel entry/abort counter ports.
module wav_dfi_lp_responder
  import wav_dfi_lp_pkg::*;
#(
  parameter int unsigned TLP_RESP = 8,
  parameter int unsigned MAX_EXIT = 63,
  parameter int unsigned DLY_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lp_ctrl_req,
  input  logic [LP_WAKEUP_W-1:0] lp_ctrl_wakeup,
  input  logic                   lp_data_req,
  input  logic [LP_WAKEUP_W-1:0] lp_data_wakeup,
  input  logic [DLY_W-1:0]       cfg_resp_dly,
  input  logic                   cfg_ctrl_allow,
  input  logic                   cfg_data_allow,
  output logic                   lp_ctrl_ack,
  output logic                   lp_data_ack,
  output logic                   lp_ctrl_active,
  output logic                   lp_data_active
`ifdef WAV_DFI_LP_RESP_STATS_EN
  ,
  output logic [15:0]            lp_ctrl_entries,
  output logic [15:0]            lp_ctrl_aborts,
  output logic [15:0]            lp_data_entries,
  output logic [15:0]            lp_data_aborts
`endif
);

  wav_dfi_lp_chan #(
    .TLP_RESP (TLP_RESP),
    .MAX_EXIT (MAX_EXIT),
    .DLY_W    (DLY_W)
  ) u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .req          (lp_ctrl_req),
    .wakeup       (lp_ctrl_wakeup),
    .cfg_resp_dly (cfg_resp_dly),
    .cfg_allow    (cfg_ctrl_allow),
    .ack          (lp_ctrl_ack),
    .active       (lp_ctrl_active)
`ifdef WAV_DFI_LP_RESP_STATS_EN
    ,
    .entries      (lp_ctrl_entries),
    .aborts       (lp_ctrl_aborts)
`endif
  );

  wav_dfi_lp_chan #(
    .TLP_RESP (TLP_RESP),
    .MAX_EXIT (MAX_EXIT),
    .DLY_W    (DLY_W)
  ) u_data (
    .clock        (clock),
    .reset        (reset),
    .req          (lp_data_req),
    .wakeup       (lp_data_wakeup),
    .cfg_resp_dly (cfg_resp_dly),
    .cfg_allow    (cfg_data_allow),
    .ack          (lp_data_ack),
    .active       (lp_data_active)
`ifdef WAV_DFI_LP_RESP_STATS_EN
    ,
    .entries      (lp_data_entries),
    .aborts       (lp_data_aborts)
`endif
  );

endmodule

// File: tb/tb_wav_dfi_lp_responder.sv
// Directed self-checking bench for wav_dfi_lp_responder (MAX_EXIT overridden to 10).
// Stats checks are included when WAV_DFI_LP_RESP_STATS_EN is defined.
module tb_wav_dfi_lp_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       lp_ctrl_req, lp_data_req;
  logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
  logic [7:0] cfg_resp_dly;
  logic       cfg_ctrl_allow, cfg_data_allow;
  logic       lp_ctrl_ack, lp_data_ack, lp_ctrl_active, lp_data_active;
`ifdef WAV_DFI_LP_RESP_STATS_EN
  logic [15:0] lp_ctrl_entries, lp_ctrl_aborts, lp_data_entries, lp_data_aborts;
`endif

  int total = 0;
  int bad   = 0;

  wav_dfi_lp_responder #(
    .TLP_RESP (8),
    .MAX_EXIT (10),
    .DLY_W    (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .lp_ctrl_req    (lp_ctrl_req),
    .lp_ctrl_wakeup (lp_ctrl_wakeup),
    .lp_data_req    (lp_data_req),
    .lp_data_wakeup (lp_data_wakeup),
    .cfg_resp_dly   (cfg_resp_dly),
    .cfg_ctrl_allow (cfg_ctrl_allow),
    .cfg_data_allow (cfg_data_allow),
    .lp_ctrl_ack    (lp_ctrl_ack),
    .lp_data_ack    (lp_data_ack),
    .lp_ctrl_active (lp_ctrl_active),
    .lp_data_active (lp_data_active)
`ifdef WAV_DFI_LP_RESP_STATS_EN
    ,
    .lp_ctrl_entries(lp_ctrl_entries),
    .lp_ctrl_aborts (lp_ctrl_aborts),
    .lp_data_entries(lp_data_entries),
    .lp_data_aborts (lp_data_aborts)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ctrl-channel handshake: hold req for 'hold' ticks, then drop and watch the exit.
  task automatic handshake(input string tag, input int dly, input int wk, input int hold,
                           input int exp_exit);
    cfg_resp_dly   = 8'(dly);
    lp_ctrl_wakeup = 6'(wk);
    lp_ctrl_req    = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      tick();
      chk({tag, "_ack_on"}, 32'(lp_ctrl_ack), 32'(i >= dly + 2));
      chk({tag, "_act_on"}, 32'(lp_ctrl_active), 32'(i >= dly + 2));
    end
    lp_ctrl_req = 1'b0;
    for (int i = 1; i <= exp_exit + 3; i++) begin
      tick();
      chk({tag, "_ack_off"}, 32'(lp_ctrl_ack), 32'(i < exp_exit + 2));
      chk({tag, "_act_off"}, 32'(lp_ctrl_active), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    lp_ctrl_req = 1'b0; lp_data_req = 1'b0;
    lp_ctrl_wakeup = '0; lp_data_wakeup = '0;
    cfg_resp_dly = '0; cfg_ctrl_allow = 1'b1; cfg_data_allow = 1'b1;
    tick(); tick();
    chk("rst_ctrl_ack", 32'(lp_ctrl_ack), 32'd0);
    chk("rst_data_ack", 32'(lp_data_ack), 32'd0);
    chk("rst_ctrl_act", 32'(lp_ctrl_active), 32'd0);
    chk("rst_data_act", 32'(lp_data_active), 32'd0);
    reset = 1'b0;
    tick();

    // 1: delay 3, accept, wakeup 2
    handshake("t1", 3, 2, 10, 2);
    chk("t1_data_idle", 32'(lp_data_ack), 32'd0);
`ifdef WAV_DFI_LP_RESP_STATS_EN
    chk("t1_entries", 32'(lp_ctrl_entries), 32'd1);
`endif

    // 2: denied by allow=0, then abort; a zero-delay request proves the FSM is back in IDLE
    cfg_ctrl_allow = 1'b0; cfg_resp_dly = 8'd3; lp_ctrl_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t2_deny_ack", 32'(lp_ctrl_ack), 32'd0);
    end
    lp_ctrl_req = 1'b0;
    tick();
    chk("t2_abort_ack", 32'(lp_ctrl_ack), 32'd0);
`ifdef WAV_DFI_LP_RESP_STATS_EN
    chk("t2_aborts", 32'(lp_ctrl_aborts), 32'd1);
`endif
    cfg_ctrl_allow = 1'b1;
    handshake("t2_idle", 0, 0, 3, 0);

    // 3: delay 8 exceeds TLP_RESP=8 -> no ack; delay 7 is the largest accepted
    cfg_resp_dly = 8'd8; lp_ctrl_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("t3_tlp_ack", 32'(lp_ctrl_ack), 32'd0);
    end
    lp_ctrl_req = 1'b0;
    tick();
    handshake("t3_dly7", 7, 1, 12, 1);

    // 4: wakeup 2->5 during ACK gives a 6-cycle exit; wakeup 63 clamps to 10
    cfg_resp_dly = 8'd1; lp_ctrl_wakeup = 6'd2; lp_ctrl_req = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk("t4_in_ack", 32'(lp_ctrl_ack), 32'd1);
    lp_ctrl_wakeup = 6'd5;
    tick(); tick();
    lp_ctrl_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t4_wk5_ack", 32'(lp_ctrl_ack), 32'(i < 7));
    end
    handshake("t4_clamp", 1, 63, 4, 10);

    // 5: overlapping channels, shared delay 2, data starts 3 cycles later; reset in EXIT
    cfg_resp_dly = 8'd2; lp_ctrl_wakeup = 6'd5; lp_data_wakeup = 6'd5;
    lp_ctrl_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) lp_data_req = 1'b1;
      chk("t5_ctrl_ack", 32'(lp_ctrl_ack), 32'(i >= 4));
      chk("t5_data_ack", 32'(lp_data_ack), 32'(i >= 7));
    end
    lp_ctrl_req = 1'b0;
    tick();
    chk("t5_ctrl_exit_ack", 32'(lp_ctrl_ack), 32'd1);
    chk("t5_ctrl_exit_act", 32'(lp_ctrl_active), 32'd0);
    chk("t5_data_act", 32'(lp_data_active), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_rst_ctrl_ack", 32'(lp_ctrl_ack), 32'd0);
    chk("t5_rst_data_ack", 32'(lp_data_ack), 32'd0);
    chk("t5_rst_data_act", 32'(lp_data_active), 32'd0);
    reset = 1'b0; lp_data_req = 1'b0;
    tick();
    chk("t5_post_data_ack", 32'(lp_data_ack), 32'd0);
`ifdef WAV_DFI_LP_RESP_STATS_EN
    chk("t5_rst_entries", 32'(lp_ctrl_entries), 32'd0);
`endif

    // 6: req reasserted during EXIT is ignored until IDLE
    cfg_resp_dly = 8'd1; lp_ctrl_wakeup = 6'd3; lp_ctrl_req = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    chk("t6_in_ack", 32'(lp_ctrl_ack), 32'd1);
    lp_ctrl_req = 1'b0;
    tick();
    lp_ctrl_req = 1'b1;
    for (int j = 2; j <= 10; j++) begin
      tick();
      chk("t6_rereq_ack", 32'(lp_ctrl_ack), 32'((j <= 4) || (j >= 8)));
    end
    lp_ctrl_req = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk("t6_idle", 32'(lp_ctrl_ack), 32'd0);
    handshake("t6_zero", 0, 0, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
